// File: rtl/sr_pkg.sv
// Shared constants for the synchronous set/reset flip-flop bank.
// Command pairs are {s, r}; conflict modes select the s=r=1 response.
package sr_pkg;

  localparam int CM_RESET_DOM = 0;
  localparam int CM_SET_DOM   = 1;
  localparam int CM_HOLD      = 2;
  localparam int CM_TOGGLE    = 3;

  localparam int FILT_W = 4;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_BOTH = 2'b11
  } cmd_e;

endpackage

// File: rtl/sr_ff_cell.sv
// One channel: run-length command filter, fire decode, latched q/q_n,
// registered edge pulses and a sticky conflict flag.
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int   FILTER        = 1,
  parameter int   CONFLICT_MODE = CM_RESET_DOM,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic conflict_clr,
  output logic q,
  output logic q_n,
  output logic rise,
  output logic fall,
  output logic conflict
);

  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER);
  localparam logic [FILT_W-1:0] ONE      = FILT_W'(1);

  cmd_e              c;
  cmd_e              p;
  cmd_e              p_next;
  logic [FILT_W-1:0] cnt;
  logic [FILT_W-1:0] cnt_next;
  logic              fire;
  logic              q_next;

  assign c = cmd_e'({s, r});

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    p_next   = c;
    cnt_next = ONE;
    if (!en) begin
      p_next   = CMD_IDLE;
      cnt_next = '0;
    end else if (c == p) begin
      cnt_next = (cnt < FILT_MAX) ? cnt + ONE : FILT_MAX;
    end

    // Fires only on the edge the run first reaches FILTER, so a held command acts once.
    fire = en && (c != CMD_IDLE) && (cnt_next == FILT_MAX) &&
           ((c != p) || (cnt < FILT_MAX));

    q_next = q;
    if (fire) begin
      case (c)
        CMD_SET:  q_next = 1'b1;
        CMD_RST:  q_next = 1'b0;
        CMD_BOTH: begin
          case (CONFLICT_MODE)
            CM_RESET_DOM: q_next = 1'b0;
            CM_SET_DOM:   q_next = 1'b1;
            CM_TOGGLE:    q_next = ~q;
            default:      q_next = q;
          endcase
        end
        default:  q_next = q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= INIT;
      q_n      <= ~INIT;
      rise     <= 1'b0;
      fall     <= 1'b0;
      conflict <= 1'b0;
      p        <= CMD_IDLE;
      cnt      <= '0;
    end else begin
      q        <= q_next;
      q_n      <= ~q_next;
      rise     <= q_next & ~q;
      fall     <= ~q_next & q;
      conflict <= (fire && (c == CMD_BOTH)) | (conflict & ~conflict_clr);
      p        <= p_next;
      cnt      <= cnt_next;
    end
  end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent synchronous set/reset flip-flops with glitch
// filtering; each bit is one sr_ff_cell.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               FILTER        = 1,
  parameter int               CONFLICT_MODE = CM_RESET_DOM,
  parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict
);

  if (FILTER < 1 || FILTER > 15) begin : g_bad_filter
    $error("sr_ff_bank: FILTER must be in 1..15");
  end
  if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: CONFLICT_MODE must be in 0..3");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .FILTER        (FILTER),
      .CONFLICT_MODE (CONFLICT_MODE),
      .INIT          (INIT[i])
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .s            (s[i]),
      .r            (r[i]),
      .conflict_clr (conflict_clr[i]),
      .q            (q[i]),
      .q_n          (q_n[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .conflict     (conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: six instances with different parameters
// share one stimulus stream; expected values are hand-computed constants.
module tb_sr_ff_bank;

  localparam int R  = 0;  // INIT=A5, FILTER=2, reset-dominant
  localparam int M0 = 1;  // FILTER=1, mode 0
  localparam int M1 = 2;  // FILTER=1, mode 1
  localparam int M2 = 3;  // FILTER=1, mode 2
  localparam int M3 = 4;  // FILTER=1, mode 3
  localparam int F3 = 5;  // FILTER=3, mode 0

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] clr;
  logic [7:0] q    [6];
  logic [7:0] qn   [6];
  logic [7:0] rise [6];
  logic [7:0] fall [6];
  logic [7:0] conf [6];

  int n_checks = 0;
  int n_errors = 0;

  sr_ff_bank #(.WIDTH(8), .FILTER(2), .CONFLICT_MODE(0), .INIT(8'hA5)) u_r (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .conflict_clr(clr),
    .q(q[R]), .q_n(qn[R]), .rise(rise[R]), .fall(fall[R]), .conflict(conf[R]));
  sr_ff_bank #(.WIDTH(8), .FILTER(1), .CONFLICT_MODE(0), .INIT(8'h00)) u_m0 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .conflict_clr(clr),
    .q(q[M0]), .q_n(qn[M0]), .rise(rise[M0]), .fall(fall[M0]), .conflict(conf[M0]));
  sr_ff_bank #(.WIDTH(8), .FILTER(1), .CONFLICT_MODE(1), .INIT(8'h00)) u_m1 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .conflict_clr(clr),
    .q(q[M1]), .q_n(qn[M1]), .rise(rise[M1]), .fall(fall[M1]), .conflict(conf[M1]));
  sr_ff_bank #(.WIDTH(8), .FILTER(1), .CONFLICT_MODE(2), .INIT(8'h00)) u_m2 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .conflict_clr(clr),
    .q(q[M2]), .q_n(qn[M2]), .rise(rise[M2]), .fall(fall[M2]), .conflict(conf[M2]));
  sr_ff_bank #(.WIDTH(8), .FILTER(1), .CONFLICT_MODE(3), .INIT(8'h00)) u_m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .conflict_clr(clr),
    .q(q[M3]), .q_n(qn[M3]), .rise(rise[M3]), .fall(fall[M3]), .conflict(conf[M3]));
  sr_ff_bank #(.WIDTH(8), .FILTER(3), .CONFLICT_MODE(0), .INIT(8'h00)) u_f3 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .conflict_clr(clr),
    .q(q[F3]), .q_n(qn[F3]), .rise(rise[F3]), .fall(fall[F3]), .conflict(conf[F3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s = 8'h00; r = 8'h00; clr = 8'h00; en = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset overrides a held set on every channel.
    rst_n = 1'b0; en = 1'b1; s = 8'hFF; r = 8'h00; clr = 8'h00;
    tick(2);
    check("rst_q",     q[R],    8'hA5);
    check("rst_qn",    qn[R],   8'h5A);
    check("rst_rise",  rise[R], 8'h00);
    check("rst_fall",  fall[R], 8'h00);
    check("rst_conf",  conf[R], 8'h00);
    check("rst_m0_q",  q[M0],   8'h00);
    check("rst_m0_qn", qn[M0],  8'hFF);

    // Release with s held: FILTER=2 needs two edges, FILTER=1 one.
    rst_n = 1'b1;
    tick();
    check("rel_e1_q",    q[R],  8'hA5);
    check("rel_e1_m0_q", q[M0], 8'hFF);
    tick();
    check("rel_e2_q",    q[R],    8'hFF);
    check("rel_e2_qn",   qn[R],   8'h00);
    check("rel_e2_rise", rise[R], 8'h5A);
    check("rel_f3_e2_q", q[F3],   8'h00);
    tick();
    check("rel_e3_rise", rise[R], 8'h00);
    check("rel_f3_e3_q", q[F3],   8'hFF);

    // Filter, FILTER=3: a two-edge burst is rejected, a three-edge burst fires.
    do_reset();
    s = 8'h01;
    tick(2);
    check("flt_burst1_q", q[F3], 8'h00);
    s = 8'h00;
    tick();
    check("flt_gap_q", q[F3], 8'h00);
    s = 8'h01;
    tick(2);
    check("flt_burst2_e2_q", q[F3], 8'h00);
    tick();
    check("flt_burst2_e3_q",    q[F3],    8'h01);
    check("flt_burst2_e3_rise", rise[F3], 8'h01);
    tick();
    check("flt_rise_done", rise[F3], 8'h00);
    check("flt_q_hold",    q[F3],    8'h01);

    // Conflict modes with q[1]=1 beforehand.
    do_reset();
    s = 8'h02;
    tick();
    check("cm_pre_m0_q", q[M0], 8'h02);
    check("cm_pre_m3_q", q[M3], 8'h02);
    r = 8'h02;
    tick();
    check("cm0_q",    q[M0],    8'h00);
    check("cm0_fall", fall[M0], 8'h02);
    check("cm1_q",    q[M1],    8'h02);
    check("cm1_fall", fall[M1], 8'h00);
    check("cm1_rise", rise[M1], 8'h00);
    check("cm2_q",    q[M2],    8'h02);
    check("cm3_q",    q[M3],    8'h00);
    check("cm3_fall", fall[M3], 8'h02);
    check("cm0_conf", conf[M0], 8'h02);
    check("cm1_conf", conf[M1], 8'h02);
    check("cm2_conf", conf[M2], 8'h02);
    check("cm3_conf", conf[M3], 8'h02);
    tick(3);
    check("cm3_held_q",  q[M3],    8'h00);
    check("cm3_held_qn", qn[M3],   8'hFF);
    check("cm0_held_fl", fall[M0], 8'h00);
    check("cm1_held_q",  q[M1],    8'h02);
    check("cm2_held_q",  q[M2],    8'h02);
    check("cm2_sticky",  conf[M2], 8'h02);
    check("cm3_sticky",  conf[M3], 8'h02);

    // Clear racing a fresh qualified 11 fire: set wins, then clear acts.
    s = 8'h00; r = 8'h00;
    tick();
    check("clr_idle_conf", conf[M0], 8'h02);
    s = 8'h02; r = 8'h02; clr = 8'h02;
    tick();
    check("clr_race_conf", conf[M0], 8'h02);
    tick();
    check("clr_after_conf", conf[M0], 8'h00);
    clr = 8'h00;

    // Enable gating: a held command is ignored, then requalifies from scratch.
    do_reset();
    en = 1'b0; s = 8'h0F;
    tick(5);
    check("en_off_m0_q", q[M0], 8'h00);
    check("en_off_f3_q", q[F3], 8'h00);
    en = 1'b1;
    tick();
    check("en_on_e1_m0_q", q[M0], 8'h0F);
    check("en_on_e1_f3_q", q[F3], 8'h00);
    tick();
    check("en_on_e2_f3_q", q[F3], 8'h00);
    tick();
    check("en_on_e3_f3_q", q[F3], 8'h0F);

    // Set then reset back-to-back, FILTER=1.
    do_reset();
    s = 8'h04;
    tick();
    check("b2b_set_q",    q[M0],    8'h04);
    check("b2b_set_rise", rise[M0], 8'h04);
    check("b2b_set_fall", fall[M0], 8'h00);
    s = 8'h00; r = 8'h04;
    tick();
    check("b2b_rst_q",    q[M0],    8'h00);
    check("b2b_rst_rise", rise[M0], 8'h00);
    check("b2b_rst_fall", fall[M0], 8'h04);
    r = 8'h00;
    tick();
    check("b2b_idle_q",    q[M0],    8'h00);
    check("b2b_idle_fall", fall[M0], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
